// File: rtl/bloom_cmd_frontend.sv
// rtl/bloom_cmd_frontend.sv - command FIFO and single-outstanding issue FSM
// in front of the bloom filter core, returning one tagged response per command.
module bloom_cmd_frontend #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [31:0]                cmd_data,
  input  logic [TAG_W-1:0]           cmd_tag,
  output logic                       bf_insert,
  output logic                       bf_query,
  output logic [31:0]                bf_data,
  input  logic                       bf_busy,
  input  logic                       bf_match,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_op,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_match,
  output logic                       rsp_err,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = 1 + 32 + TAG_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [ENT_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               op_q, op_d;
  logic [31:0]        data_q, data_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q, match_d;
  logic               err_q, err_d;

  logic push;
  logic pop;
  logic timed_out;
  logic [CNT_W-1:0] cnt_inc;

  assign cmd_ready = (level_q != LVL_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // Popping only from IDLE keeps exactly one command outstanding to the core.
  assign pop       = (state_q == S_IDLE) && (level_q != '0);
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT));
  assign cnt_inc   = timed_out ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_op, cmd_data, cmd_tag};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    tag_d   = tag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          {op_d, data_d, tag_d} = mem_q[rd_ptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        acc_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (timed_out) begin
          match_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (bf_busy) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d = cnt_inc;
        if (op_q) begin
          acc_d = acc_q | bf_match;
        end
        // Timeout wins over a core that finishes in the same cycle.
        if (timed_out) begin
          match_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (!bf_busy) begin
          match_d = acc_q & op_q;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      op_q     <= 1'b0;
      data_q   <= '0;
      tag_q    <= '0;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      op_q     <= op_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      err_q    <= err_d;
    end
  end

  assign bf_insert  = (state_q == S_ISSUE) && !op_q;
  assign bf_query   = (state_q == S_ISSUE) && op_q;
  assign bf_data    = data_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_op     = op_q;
  assign rsp_tag    = tag_q;
  assign rsp_match  = match_q;
  assign rsp_err    = err_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_bloom_cmd_frontend.sv
// tb/tb_bloom_cmd_frontend.sv - randomized bench with core model and response scoreboard
module tb_bloom_cmd_frontend;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_tag = '0;
  logic        bf_insert, bf_query;
  logic [31:0] bf_data;
  logic        bf_busy = 1'b0;
  logic        bf_match = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_op;
  logic [3:0]  rsp_tag;
  logic        rsp_match, rsp_err;
  logic [2:0]  fifo_level;

  bloom_cmd_frontend #(.DEPTH(4), .TAG_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_tag(cmd_tag),
    .bf_insert(bf_insert), .bf_query(bf_query), .bf_data(bf_data),
    .bf_busy(bf_busy), .bf_match(bf_match),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_tag(rsp_tag), .rsp_match(rsp_match), .rsp_err(rsp_err),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core model settings, driven by the stimulus process
  int          busy_len = 2;
  bit          never_busy = 1'b0;
  bit [31:0]   hit_key = 32'h5;
  int          rdy_mode = 1;

  int rem = 0;
  bit hit_pend = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_busy  <= 1'b0;
      bf_match <= 1'b0;
      rem      <= 0;
      hit_pend <= 1'b0;
    end else if ((bf_insert || bf_query) && !never_busy) begin
      bf_busy  <= 1'b1;
      bf_match <= (busy_len == 1) && bf_query && (bf_data == hit_key);
      rem      <= busy_len - 1;
      hit_pend <= bf_query && (bf_data == hit_key);
    end else if (rem > 0) begin
      bf_busy  <= 1'b1;
      bf_match <= (rem == 1) && hit_pend;
      rem      <= rem - 1;
    end else begin
      bf_busy  <= 1'b0;
      bf_match <= 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit       op;
    bit [3:0] tag;
    bit       match;
    bit       err;
  } exp_t;
  exp_t sb[$];

  int       n_cmd = 0, n_rsp = 0, n_strobe = 0;
  int       strobe_cyc = 0, rise_cyc = 0;
  bit [31:0] strobe_data = '0;
  bit       strobe_was_ins = 1'b0;
  bit       hold = 1'b0, prev_valid = 1'b0;
  bit [6:0] held = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      hold = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        e.op    = cmd_op;
        e.tag   = cmd_tag;
        e.err   = never_busy;
        e.match = cmd_op && (cmd_data == hit_key) && !never_busy;
        sb.push_back(e);
        n_cmd++;
      end
      if (bf_insert || bf_query) begin
        check("strobe_excl", 64'(bf_insert && bf_query), 64'd0);
        n_strobe++;
        strobe_cyc = cyc;
        strobe_data = bf_data;
        strobe_was_ins = bf_insert;
      end
      if (rsp_valid && !prev_valid) rise_cyc = cyc;
      if (hold) begin
        check("hold_valid", 64'(rsp_valid), 64'd1);
        check("hold_fields", 64'({rsp_op, rsp_tag, rsp_match, rsp_err}), 64'(held));
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
          check("rsp_op", 64'(rsp_op), 64'(e.op));
          check("rsp_match", 64'(rsp_match), 64'(e.match));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
      hold = rsp_valid && !rsp_ready;
      held = {rsp_op, rsp_tag, rsp_match, rsp_err};
      prev_valid = rsp_valid;
    end
  end

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("cmd_accept", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send(input bit op, input bit [31:0] d, input bit [3:0] t);
    cmd_op = op;
    cmd_data = d;
    cmd_tag = t;
    cmd_valid = 1'b1;
    wait_accept();
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || fifo_level != 0 || rsp_valid || bf_busy) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("drain", 64'(n < 1000), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_level"}, 64'(fifo_level), 64'd0);
    check({tag, "_outs"}, 64'({bf_insert, bf_query, bf_data, rsp_valid, rsp_op,
                                rsp_tag, rsp_match, rsp_err}), 64'd0);
  endtask

  int c0;
  int snap;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single insert: latency and strobe content
    rdy_mode = 1;
    busy_len = 2;
    c0 = cyc;
    send(1'b0, 32'h5, 4'd3);
    drain();
    check("ins_strobe_lat", 64'(strobe_cyc - c0), 64'd2);
    check("ins_strobe_data", 64'(strobe_data), 64'h5);
    check("ins_strobe_kind", 64'(strobe_was_ins), 64'd1);
    check("ins_rsp_lat", 64'(rise_cyc - c0), 64'd6);

    // Query hit then miss
    busy_len = 3;
    c0 = cyc;
    send(1'b1, 32'h5, 4'd1);
    drain();
    check("qry_rsp_lat", 64'(rise_cyc - c0), 64'd7);
    send(1'b1, 32'h9, 4'd2);
    drain();

    // FIFO full with stalled response
    rdy_mode = 0;
    busy_len = 2;
    for (int i = 0; i < 5; i++) send(1'($urandom_range(0, 1)), 32'h5, 4'(i + 4));
    check("full_level", 64'(fifo_level), 64'd4);
    cmd_op = 1'b1;
    cmd_data = 32'h5;
    cmd_tag = 4'd9;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_refused", 64'(cmd_ready), 64'd0);
    end
    rdy_mode = 1;
    wait_accept();
    drain();

    // Timeout: core never responds
    never_busy = 1'b1;
    send(1'b1, 32'h5, 4'd7);
    drain();
    check("timeout_lat", 64'(rise_cyc - strobe_cyc), 64'd18);
    never_busy = 1'b0;
    send(1'b1, 32'h5, 4'd8);
    drain();

    // Randomized backpressure and traffic
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      busy_len = $urandom_range(2, 4);
      case ($urandom_range(0, 2))
        0:       send(1'($urandom_range(0, 1)), 32'h5, 4'(i));
        1:       send(1'($urandom_range(0, 1)), 32'h9, 4'(i));
        default: send(1'($urandom_range(0, 1)), $urandom, 4'(i));
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();

    // Reset while a query sits in DONE, with another command queued
    rdy_mode = 1;
    busy_len = 6;
    send(1'b1, 32'h5, 4'd10);
    send(1'b0, 32'h9, 4'd11);
    begin
      int n = 0;
      @(negedge clk);
      while (!bf_busy && n < 50) begin
        n++;
        @(negedge clk);
      end
      check("reach_busy", 64'(bf_busy), 64'd1);
    end
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    snap = n_rsp;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_rsp_after_reset", 64'(n_rsp - snap), 64'd0);

    check("rsp_count", 64'(n_rsp), 64'(n_cmd - 2));
    check("strobe_count", 64'(n_strobe), 64'(n_rsp + 1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
